// File: rtl/default_round_layer.sv
// One registered round of the DEFAULT-style 128-bit SPN cipher: S-layer, bit permutation,
// key XOR and round constant on the state path, plus the unkeyed key-schedule round.
module default_round_layer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [127:0] res,
    input  logic [127:0] rkey,
    input  logic [4:0]   rc,
    input  logic [1:0]   rcc,
    output logic [127:0] te,
    output logic [127:0] tkey,
    output logic         out_valid
);

    logic [127:0] te_q, te_d;
    logic [127:0] tkey_q, tkey_d;
    logic         out_valid_q;

    function automatic logic [3:0] sbox_ls(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h0;  4'h1: y = 4'h3;  4'h2: y = 4'h7;  4'h3: y = 4'hE;
            4'h4: y = 4'hD;  4'h5: y = 4'h4;  4'h6: y = 4'hA;  4'h7: y = 4'h9;
            4'h8: y = 4'hC;  4'h9: y = 4'hF;  4'hA: y = 4'h1;  4'hB: y = 4'h8;
            4'hC: y = 4'hB;  4'hD: y = 4'h2;  4'hE: y = 4'h6;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_core(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h1;  4'h1: y = 4'h9;  4'h2: y = 4'h6;  4'h3: y = 4'hF;
            4'h4: y = 4'h7;  4'h5: y = 4'hC;  4'h6: y = 4'h8;  4'h7: y = 4'h2;
            4'h8: y = 4'hA;  4'h9: y = 4'hE;  4'hA: y = 4'hD;  4'hB: y = 4'h0;
            4'hC: y = 4'h4;  4'hD: y = 4'h3;  4'hE: y = 4'hB;  default: y = 4'h5;
        endcase
        return y;
    endfunction

    // Pure wiring once the loop is unrolled: bit i lands at its fixed destination.
    function automatic logic [127:0] perm(input logic [127:0] x);
        logic [127:0] y;
        logic [6:0]   d;
        y = '0;
        for (int i = 0; i < 128; i++) begin
            d = 7'(4 * (i / 16) + 32 * ((3 * ((i % 16) / 4) + (i % 4)) % 4) + (i % 4));
            y[d] = x[i];
        end
        return y;
    endfunction

    // Unrolled 6-bit LFSR from an all-zero seed; term n is the constant for rc=n.
    function automatic logic [5:0] round_const(input logic [4:0] n);
        logic [5:0] c;
        c = '0;
        for (int k = 1; k <= 28; k++) begin
            if (k <= int'(n)) c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
        end
        return c;
    endfunction

    function automatic logic [127:0] add_const(input logic [127:0] x, input logic [4:0] n);
        logic [127:0] y;
        logic [5:0]   c;
        y = x;
        if (n != 5'd0 && n <= 5'd28) begin
            c = round_const(n);
            y[23]  = y[23] ^ c[5];
            y[19]  = y[19] ^ c[4];
            y[15]  = y[15] ^ c[3];
            y[11]  = y[11] ^ c[2];
            y[7]   = y[7]  ^ c[1];
            y[3]   = y[3]  ^ c[0];
            y[127] = ~y[127];
        end
        return y;
    endfunction

    logic [127:0] s_state, s_key;

    always_comb begin
        s_state = '0;
        s_key   = '0;
        for (int j = 0; j < 32; j++) begin
            s_state[4*j +: 4] = (rcc == 2'b01) ? sbox_core(res[4*j +: 4]) : sbox_ls(res[4*j +: 4]);
            s_key[4*j +: 4]   = sbox_core(rkey[4*j +: 4]);
        end
    end

    // rcc=11 turns the round into a plain pipeline register.
    always_comb begin
        te_d   = add_const(perm(s_state) ^ rkey, rc);
        tkey_d = add_const(perm(s_key), rc);
        if (rcc == 2'b11) begin
            te_d   = res;
            tkey_d = rkey;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            te_q        <= '0;
            tkey_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                te_q   <= te_d;
                tkey_q <= tkey_d;
            end
        end
    end

    assign te        = te_q;
    assign tkey      = tkey_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_default_round_layer.sv
// Self-checking bench for default_round_layer: directed vectors from the cipher definition
// plus randomized back-to-back beats checked against a table-driven reference model.
module tb_default_round_layer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] res, rkey;
    logic [4:0]   rc;
    logic [1:0]   rcc;
    logic [127:0] te, tkey;
    logic         out_valid;

    default_round_layer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .res(res), .rkey(rkey),
        .rc(rc), .rcc(rcc), .te(te), .tkey(tkey), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_q[$];
    logic [255:0] last_exp;

    int s_ls[16]   = '{0, 3, 7, 14, 13, 4, 10, 9, 12, 15, 1, 8, 11, 2, 6, 5};
    int s_core[16] = '{1, 9, 6, 15, 7, 12, 8, 2, 10, 14, 13, 0, 4, 3, 11, 5};
    int perm_tab[128];
    logic [5:0] c_tab[32];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] model_const(input logic [127:0] x, input int n);
        logic [127:0] y;
        y = x;
        if (n >= 1 && n <= 28) begin
            for (int b = 0; b < 6; b++) y[3 + 4*b] ^= c_tab[n][b];
            y[127] ^= 1'b1;
        end
        return y;
    endfunction

    // Returns {te, tkey} for one beat.
    function automatic logic [255:0] model(input logic [127:0] r, input logic [127:0] k,
                                           input int n, input int phase);
        logic [127:0] sr, sk, pr, pk;
        if (phase == 3) return {r, k};
        pr = '0;
        pk = '0;
        for (int j = 0; j < 32; j++) begin
            sr[4*j +: 4] = 4'((phase == 1) ? s_core[r[4*j +: 4]] : s_ls[r[4*j +: 4]]);
            sk[4*j +: 4] = 4'(s_core[k[4*j +: 4]]);
        end
        for (int i = 0; i < 128; i++) begin
            pr[perm_tab[i]] = sr[i];
            pk[perm_tab[i]] = sk[i];
        end
        return {model_const(pr ^ k, n), model_const(pk, n)};
    endfunction

    // One clock with the given inputs; valid beats go through the expected queue.
    task automatic step(input string tag, input logic v, input logic [127:0] r,
                        input logic [127:0] k, input logic [4:0] n, input logic [1:0] phase);
        logic [255:0] e;
        in_valid = v;
        res      = r;
        rkey     = k;
        rc       = n;
        rcc      = phase;
        if (v) exp_q.push_back(model(r, k, int'(n), int'(phase)));
        @(posedge clk);
        #1;
        if (v) begin
            e = exp_q.pop_front();
            last_exp = e;
        end else begin
            e = last_exp;
        end
        check({tag, "_data"}, {te, tkey}, e);
        check({tag, "_valid"}, {255'b0, out_valid}, {255'b0, v});
    endtask

    logic [127:0] ones_pat, core_pat, ls_pat;
    logic [5:0]   c;

    initial begin
        for (int i = 0; i < 128; i++)
            perm_tab[i] = 4*(i/16) + 32*((3*((i%16)/4) + (i%4)) % 4) + (i%4);
        c = '0;
        c_tab[0] = '0;
        for (int n = 1; n < 32; n++) begin
            if (n <= 28) begin
                c = {c[4:0], c[5] ^ c[4] ^ 1'b1};
                c_tab[n] = c;
            end else begin
                c_tab[n] = '0;
            end
        end
        ones_pat = {32{4'h1}};
        core_pat = {4'h9, {30{4'h1}}, 4'h9};
        ls_pat   = {4'h8, 120'h0, 4'h8};

        // Reset held with a live beat on the inputs.
        rst_n = 1'b0; in_valid = 1'b1; res = rand128(); rkey = rand128(); rc = 5'd3; rcc = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", {te, tkey}, 256'h0);
        check("reset_valid", {255'b0, out_valid}, 256'h0);
        rst_n = 1'b1;
        last_exp = '0;
        step("idle", 1'b0, rand128(), rand128(), 5'd1, 2'b00);

        step("ls_zero_rc0", 1'b1, 128'h0, 128'h0, 5'd0, 2'b00);
        check("ls_zero_rc0_tkey", {128'h0, tkey}, {128'h0, ones_pat});
        step("core_zero_rc1", 1'b1, 128'h0, 128'h0, 5'd1, 2'b01);
        check("core_zero_rc1_te", {128'h0, te}, {128'h0, core_pat});
        check("core_zero_rc1_tkey", {128'h0, tkey}, {128'h0, core_pat});
        step("ls2_zero_rc1", 1'b1, 128'h0, 128'h0, 5'd1, 2'b10);
        check("ls2_zero_rc1_te", {128'h0, te}, {128'h0, ls_pat});
        step("bypass", 1'b1, {16{8'hA5}}, {16{8'h0F}}, 5'd7, 2'b11);
        check("bypass_te", {te, tkey}, {{16{8'hA5}}, {16{8'h0F}}});
        step("hold", 1'b0, rand128(), rand128(), 5'd2, 2'b00);

        // Reset must win over a valid beat in the same cycle.
        rst_n = 1'b0; in_valid = 1'b1; res = rand128(); rkey = rand128(); rc = 5'd5; rcc = 2'b00;
        @(posedge clk);
        #1;
        check("rst_prio_data", {te, tkey}, 256'h0);
        check("rst_prio_valid", {255'b0, out_valid}, 256'h0);
        rst_n = 1'b1;
        last_exp = '0;

        // Back-to-back sweep over every phase and every rc code, including 0 and 29..31.
        for (int p = 0; p < 4; p++)
            for (int n = 0; n < 32; n++)
                step("sweep", 1'b1, rand128(), rand128(), 5'(n), 2'(p));

        // Random traffic with idle gaps.
        for (int i = 0; i < 300; i++)
            step("random", ($urandom_range(0, 3) != 0), rand128(), rand128(),
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
